// File: rtl/softusb_rx_bitproc_pkg.sv
// Shared definitions for the softusb receive bit processor: FSM states and
// default line-protocol constants.
package softusb_rx_bitproc_pkg;

   localparam int unsigned STUFF_LEN_DEF = 6;
   localparam int unsigned SYNC_MIN_DEF  = 5;
   localparam int unsigned MAX_BYTES_DEF = 1027;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR  = 3'd3,
      ST_EOP  = 3'd4
   } rx_state_t;

endpackage

// File: rtl/softusb_rx_bitproc_unstuff.sv
// NRZI decoder with consecutive-ones counter and stuffed-bit removal.
// Outputs are combinational on the current sample; the parent registers them.
module softusb_rx_bitproc_unstuff
   import softusb_rx_bitproc_pkg::*;
#(
   parameter int unsigned STUFF_LEN = STUFF_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic line_j,
   input  logic se0,
   input  logic clear,
   output logic sample,
   output logic dbit,
   output logic bit_strobe,
   output logic stuff_err
);

   localparam int unsigned OW = $clog2(STUFF_LEN + 1);

   logic          prev_j;
   logic [OW-1:0] ones;
   logic          at_stuff;

   always_comb begin
      sample     = ce & ~se0;
      dbit       = (line_j == prev_j);
      at_stuff   = (ones == OW'(STUFF_LEN));
      bit_strobe = sample & ~at_stuff;
      stuff_err  = sample & at_stuff & dbit;
   end

   // The counter runs in every state so the SYNC-final one is already counted
   // when DATA starts; it saturates at STUFF_LEN while the line idles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_j <= 1'b1;
         ones   <= '0;
      end else if (clear) begin
         prev_j <= 1'b1;
         ones   <= '0;
      end else if (sample) begin
         prev_j <= line_j;
         if (!dbit)
            ones <= '0;
         else if (!at_stuff)
            ones <= ones + 1'b1;
      end
   end

endmodule

// File: rtl/softusb_rx_bitproc.sv
// USB receive bit processor: SYNC detection, byte assembly, EOP handling and
// bit-serial CRC feed, on top of the NRZI/unstuff front end.
module softusb_rx_bitproc
   import softusb_rx_bitproc_pkg::*;
#(
   parameter int unsigned STUFF_LEN = STUFF_LEN_DEF,
   parameter int unsigned SYNC_MIN  = SYNC_MIN_DEF,
   parameter int unsigned MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic       usb_clk,
   input  logic       usb_rst_n,
   input  logic       rx_ce,
   input  logic       rx_j,
   input  logic       rx_se0,
   output logic       rx_active,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_eop,
   output logic       rx_err,
   output logic       crc_reset,
   output logic       crc_ce,
   output logic       crc_data
);

   localparam int unsigned ZW = $clog2(SYNC_MIN + 1);
   localparam int unsigned BW = $clog2(MAX_BYTES + 1);

   rx_state_t     state, state_n;
   logic [ZW-1:0] zero_cnt, zero_cnt_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [BW-1:0] byte_cnt, byte_cnt_n;
   logic [6:0]    shreg, shreg_n;
   logic [7:0]    shifted;
   logic          err, err_n;
   logic [7:0]    data_n;
   logic          active_n, valid_n, eop_n, err_out_n;
   logic          crc_reset_n, crc_ce_n, crc_data_n;
   logic          clear;
   logic          sample, dbit, bit_strobe, stuff_err;
   logic          se0_ce;

   softusb_rx_bitproc_unstuff #(
      .STUFF_LEN (STUFF_LEN)
   ) u_unstuff (
      .clk        (usb_clk),
      .rst_n      (usb_rst_n),
      .ce         (rx_ce),
      .line_j     (rx_j),
      .se0        (rx_se0),
      .clear      (clear),
      .sample     (sample),
      .dbit       (dbit),
      .bit_strobe (bit_strobe),
      .stuff_err  (stuff_err)
   );

   always_comb begin
      state_n     = state;
      zero_cnt_n  = zero_cnt;
      bit_cnt_n   = bit_cnt;
      byte_cnt_n  = byte_cnt;
      shreg_n     = shreg;
      err_n       = err;
      data_n      = rx_data;
      crc_data_n  = crc_data;
      valid_n     = 1'b0;
      eop_n       = 1'b0;
      err_out_n   = 1'b0;
      crc_reset_n = 1'b0;
      crc_ce_n    = 1'b0;
      clear       = 1'b0;
      se0_ce      = rx_ce & rx_se0;
      shifted     = {dbit, shreg};

      case (state)
         ST_IDLE: begin
            if (sample && !dbit) begin
               state_n    = ST_SYNC;
               zero_cnt_n = ZW'(1);
            end
         end
         ST_SYNC: begin
            if (se0_ce) begin
               state_n = ST_IDLE;
            end else if (sample) begin
               if (!dbit) begin
                  if (zero_cnt != ZW'(SYNC_MIN))
                     zero_cnt_n = zero_cnt + 1'b1;
               end else if (zero_cnt >= ZW'(SYNC_MIN)) begin
                  state_n     = ST_DATA;
                  crc_reset_n = 1'b1;
                  bit_cnt_n   = '0;
                  byte_cnt_n  = '0;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (se0_ce) begin
               state_n = ST_EOP;
               if (bit_cnt != 3'd0)
                  err_n = 1'b1;
            end else if (stuff_err) begin
               err_n   = 1'b1;
               state_n = ST_ERR;
            end else if (bit_strobe) begin
               crc_ce_n   = 1'b1;
               crc_data_n = dbit;
               shreg_n    = shifted[7:1];
               bit_cnt_n  = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (byte_cnt == BW'(MAX_BYTES)) begin
                     err_n   = 1'b1;
                     state_n = ST_ERR;
                  end else begin
                     data_n     = shifted;
                     valid_n    = 1'b1;
                     byte_cnt_n = byte_cnt + 1'b1;
                  end
               end
            end
         end
         ST_ERR: begin
            if (se0_ce)
               state_n = ST_EOP;
         end
         ST_EOP: begin
            // Any non-SE0 sample ends EOP; a K here is an illegal EOP.
            if (sample) begin
               state_n    = ST_IDLE;
               eop_n      = 1'b1;
               err_out_n  = err | ~rx_j;
               err_n      = 1'b0;
               bit_cnt_n  = '0;
               byte_cnt_n = '0;
               clear      = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      active_n = (state_n == ST_DATA) || (state_n == ST_ERR) || (state_n == ST_EOP);
   end

   always_ff @(posedge usb_clk or negedge usb_rst_n) begin
      if (!usb_rst_n) begin
         state     <= ST_IDLE;
         zero_cnt  <= '0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         shreg     <= '0;
         err       <= 1'b0;
         rx_active <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_eop    <= 1'b0;
         rx_err    <= 1'b0;
         crc_reset <= 1'b0;
         crc_ce    <= 1'b0;
         crc_data  <= 1'b0;
      end else begin
         state     <= state_n;
         zero_cnt  <= zero_cnt_n;
         bit_cnt   <= bit_cnt_n;
         byte_cnt  <= byte_cnt_n;
         shreg     <= shreg_n;
         err       <= err_n;
         rx_active <= active_n;
         rx_data   <= data_n;
         rx_valid  <= valid_n;
         rx_eop    <= eop_n;
         rx_err    <= err_out_n;
         crc_reset <= crc_reset_n;
         crc_ce    <= crc_ce_n;
         crc_data  <= crc_data_n;
      end
   end

endmodule

// File: tb/tb_softusb_rx_bitproc.sv
// Directed bench for softusb_rx_bitproc: packet-level vector table plus
// hand-written sequences for aborted SYNC, async reset and byte overflow.
module tb_softusb_rx_bitproc;

   logic       usb_clk = 1'b0;
   logic       usb_rst_n = 1'b0;
   logic       rx_ce = 1'b0;
   logic       rx_j = 1'b1;
   logic       rx_se0 = 1'b0;
   logic       rx_active, rx_valid, rx_eop, rx_err;
   logic       crc_reset, crc_ce, crc_data;
   logic [7:0] rx_data;

   always #5 usb_clk = ~usb_clk;

   softusb_rx_bitproc dut (
      .usb_clk   (usb_clk),
      .usb_rst_n (usb_rst_n),
      .rx_ce     (rx_ce),
      .rx_j      (rx_j),
      .rx_se0    (rx_se0),
      .rx_active (rx_active),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_eop    (rx_eop),
      .rx_err    (rx_err),
      .crc_reset (crc_reset),
      .crc_ce    (crc_ce),
      .crc_data  (crc_data)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // Output monitor, sampled on the falling edge.
   bit          mon_clr = 1'b0;
   int unsigned m_valid, m_crc, m_rst, m_eop, m_err, m_viol;
   logic [7:0]  m_byte0, m_byte1, m_last;
   logic [31:0] m_stream;
   bit          seen_rst;

   always @(negedge usb_clk) begin
      if (mon_clr) begin
         m_valid  <= 0; m_crc <= 0; m_rst <= 0; m_eop <= 0; m_err <= 0; m_viol <= 0;
         m_byte0  <= '0; m_byte1 <= '0; m_last <= '0; m_stream <= '0; seen_rst <= 1'b0;
      end else begin
         if (rx_valid) begin
            if (m_valid == 0) m_byte0 <= rx_data;
            if (m_valid == 1) m_byte1 <= rx_data;
            m_last  <= rx_data;
            m_valid <= m_valid + 1;
         end
         if (crc_ce) begin
            if (m_crc < 32) m_stream[m_crc] <= crc_data;
            m_crc <= m_crc + 1;
         end
         if (crc_reset) begin
            m_rst    <= m_rst + 1;
            seen_rst <= 1'b1;
         end
         if (rx_eop) m_eop <= m_eop + 1;
         if (rx_err) m_err <= m_err + 1;
         if ((crc_ce && !seen_rst) || (crc_reset && crc_ce) ||
             (rx_eop && (rx_valid || crc_ce)) || (rx_err && !rx_eop))
            m_viol <= m_viol + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Line driver with the bench's own NRZI encoder and stuffer.
   int unsigned gap = 1;
   logic        line = 1'b1;
   int unsigned ones = 0;

   task automatic samp(input logic j, input logic se0);
      rx_j = j; rx_se0 = se0; rx_ce = 1'b1;
      @(posedge usb_clk); #1;
      if (gap > 1) begin
         rx_ce = 1'b0;
         repeat (gap - 1) begin @(posedge usb_clk); #1; end
      end
   endtask

   task automatic quiet(input int unsigned n);
      rx_ce = 1'b0;
      repeat (n) begin @(posedge usb_clk); #1; end
   endtask

   task automatic idle_j(input int unsigned n);
      repeat (n) samp(1'b1, 1'b0);
      line = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      if (!b) line = ~line;
      samp(line, 1'b0);
   endtask

   task automatic send_dbit(input logic b, input bit stuff_en);
      send_bit(b);
      if (b) ones++; else ones = 0;
      if (stuff_en && ones == 6) begin
         send_bit(1'b0);
         ones = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int k = 0; k < 8; k++) send_dbit(v[k], 1'b1);
   endtask

   task automatic send_sync();
      repeat (7) send_bit(1'b0);
      send_bit(1'b1);
      ones = 1;
   endtask

   task automatic send_eop();
      samp(1'b0, 1'b1);
      samp(1'b0, 1'b1);
      samp(1'b1, 1'b0);
      line = 1'b1;
      quiet(4);
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge usb_clk); #1;
      mon_clr = 1'b0;
      @(posedge usb_clk); #1;
   endtask

   function automatic logic [31:0] outs_flat();
      return {17'd0, rx_active, rx_valid, rx_eop, rx_err, crc_reset, crc_ce, crc_data, rx_data};
   endfunction

   typedef struct {
      logic [31:0] bits;
      int unsigned nbits;
      bit          stuff;
      int unsigned gap;
      int unsigned exp_valid;
      logic [7:0]  exp_b0;
      logic [7:0]  exp_b1;
      int unsigned exp_crc;
      bit          exp_err;
   } vec_t;

   vec_t vt[5];

   initial begin
      logic [31:0] mask;

      vt[0] = '{bits: 32'h3CA5, nbits: 16, stuff: 1, gap: 1, exp_valid: 2,
                exp_b0: 8'hA5, exp_b1: 8'h3C, exp_crc: 16, exp_err: 0};
      vt[1] = '{bits: 32'hFFFF, nbits: 16, stuff: 1, gap: 4, exp_valid: 2,
                exp_b0: 8'hFF, exp_b1: 8'hFF, exp_crc: 16, exp_err: 0};
      vt[2] = '{bits: 32'h08F4, nbits: 16, stuff: 1, gap: 2, exp_valid: 2,
                exp_b0: 8'hF4, exp_b1: 8'h08, exp_crc: 16, exp_err: 0};
      // SYNC-final one plus five data ones fill the counter; the sixth is a stuff error.
      vt[3] = '{bits: 32'h7F, nbits: 7, stuff: 0, gap: 1, exp_valid: 0,
                exp_b0: 8'h00, exp_b1: 8'h00, exp_crc: 5, exp_err: 1};
      vt[4] = '{bits: 32'h5A3, nbits: 12, stuff: 1, gap: 1, exp_valid: 1,
                exp_b0: 8'hA3, exp_b1: 8'h00, exp_crc: 12, exp_err: 1};

      repeat (3) @(posedge usb_clk);
      #1;
      check("reset_outputs", outs_flat(), 32'd0);
      usb_rst_n = 1'b1;
      quiet(2);
      check("post_reset_outputs", outs_flat(), 32'd0);

      for (int i = 0; i < 5; i++) begin
         gap = vt[i].gap;
         clear_mon();
         idle_j(3);
         send_sync();
         for (int k = 0; k < vt[i].nbits; k++) send_dbit(vt[i].bits[k], vt[i].stuff);
         send_eop();
         mask = (32'd1 << vt[i].exp_crc) - 32'd1;
         check($sformatf("v%0d.valid_cnt", i), m_valid, vt[i].exp_valid);
         if (vt[i].exp_valid >= 1) check($sformatf("v%0d.byte0", i), {24'd0, m_byte0}, {24'd0, vt[i].exp_b0});
         if (vt[i].exp_valid >= 2) check($sformatf("v%0d.byte1", i), {24'd0, m_byte1}, {24'd0, vt[i].exp_b1});
         check($sformatf("v%0d.crc_ce_cnt", i), m_crc, vt[i].exp_crc);
         check($sformatf("v%0d.crc_stream", i), m_stream & mask, vt[i].bits & mask);
         check($sformatf("v%0d.crc_reset_cnt", i), m_rst, 1);
         check($sformatf("v%0d.eop_cnt", i), m_eop, 1);
         check($sformatf("v%0d.err_cnt", i), m_err, {31'd0, vt[i].exp_err});
         check($sformatf("v%0d.strobe_overlap", i), m_viol, 0);
         check($sformatf("v%0d.active_end", i), {31'd0, rx_active}, 0);
      end

      // Short SYNC aborts silently; a following packet still decodes.
      gap = 1;
      clear_mon();
      idle_j(3);
      repeat (3) send_bit(1'b0);
      send_bit(1'b1);
      quiet(3);
      check("abort.crc_reset", m_rst, 0);
      check("abort.outputs", m_crc + m_valid + m_eop + m_err, 0);
      check("abort.active", {31'd0, rx_active}, 0);
      idle_j(4);
      send_sync();
      send_byte(8'h69);
      send_eop();
      check("abort.next_valid", m_valid, 1);
      check("abort.next_byte", {24'd0, m_byte0}, 32'h69);
      check("abort.next_eop", m_eop, 1);
      check("abort.next_err", m_err, 0);

      // Asynchronous reset mid-byte clears every output at once.
      clear_mon();
      idle_j(3);
      send_sync();
      send_byte(8'hA5);
      for (int k = 0; k < 4; k++) send_dbit(1'b1, 1'b1);
      rx_ce = 1'b0;
      #2 usb_rst_n = 1'b0;
      #1 check("midrst.outputs", outs_flat(), 32'd0);
      quiet(2);
      usb_rst_n = 1'b1;
      line = 1'b1;
      quiet(2);
      clear_mon();
      idle_j(3);
      send_sync();
      send_byte(8'hC3);
      send_eop();
      check("midrst.valid", m_valid, 1);
      check("midrst.byte", {24'd0, m_byte0}, 32'hC3);
      check("midrst.crc_ce", m_crc, 8);
      check("midrst.err", m_err, 0);

      // One byte past the packet limit is an error without rx_valid.
      clear_mon();
      idle_j(3);
      send_sync();
      for (int b = 0; b < 1028; b++) send_byte(8'(b));
      send_eop();
      check("ovf.valid_cnt", m_valid, 1027);
      check("ovf.last_byte", {24'd0, m_last}, 32'h02);
      check("ovf.eop", m_eop, 1);
      check("ovf.err", m_err, 1);
      check("ovf.strobe_overlap", m_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
